// File: rtl/procb_buf.sv
// Per-thread record queue feeding process_bytes: speculative lookup, commit next cycle.
// Optional sticky error flags: define PROCB_BUF_ERR_EN.
`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH 32
`endif

module procb_buf #(
   parameter int N_THREADS     = 16,
   parameter int N_THREADS_MSB = `MSB(N_THREADS-1),
   parameter int DEPTH         = 4,
   parameter int DEPTH_MSB     = `MSB(DEPTH-1)
) (
   input  logic                       CLK,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [N_THREADS_MSB:0]     wr_thread_num,
   input  logic [`PROCB_D_WIDTH-1:0]  din,
   output logic [N_THREADS-1:0]       full,
   input  logic [N_THREADS_MSB:0]     rd_thread_num,
   input  logic                       lookup_en,
   input  logic                       rd_en,
   input  logic                       rd_rst,
   output logic                       lookup_empty,
   output logic [`PROCB_D_WIDTH-1:0]  dout,
   output logic [2:0]                 err
);

   localparam int TW = N_THREADS_MSB + 1;
   localparam int SW = DEPTH_MSB + 1;
   localparam int CW = DEPTH_MSB + 2;
   localparam int DW = `PROCB_D_WIDTH;

   typedef logic [SW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [TW-1:0] thr_t;

   logic [DW-1:0] mem_q [N_THREADS*DEPTH];

   ptr_t wr_ptr_q [N_THREADS];
   ptr_t wr_ptr_d [N_THREADS];
   ptr_t rd_ptr_q [N_THREADS];
   ptr_t rd_ptr_d [N_THREADS];
   cnt_t cnt_q    [N_THREADS];
   cnt_t cnt_d    [N_THREADS];

   logic [N_THREADS-1:0] full_q, full_d;
   logic                 pend_q, pend_d;
   thr_t                 pend_thr_q, pend_thr_d;
   logic [DW-1:0]        dout_q, dout_d;

   logic             la, lk_ok, clr, commit, commit_wr, wr_ok;
   logic [TW+SW-1:0] rd_addr, wr_addr;

   always_comb begin
      la           = pend_q && (pend_thr_q == rd_thread_num);
      lookup_empty = (cnt_q[rd_thread_num] - cnt_t'(la)) == '0;
      lk_ok        = lookup_en & ~lookup_empty;
      clr          = rd_en & rd_rst;
      commit       = rd_en & pend_q & ~rd_rst;
      commit_wr    = commit && (pend_thr_q == wr_thread_num);
      // a commit on a full thread frees the slot the write lands in
      wr_ok        = wr_en & (~full_q[wr_thread_num] | commit_wr)
                   & ~(clr && (rd_thread_num == wr_thread_num));
      rd_addr      = {rd_thread_num, rd_ptr_q[rd_thread_num] + ptr_t'(la)};
      wr_addr      = {wr_thread_num, wr_ptr_q[wr_thread_num]};
   end

   always_comb begin
      for (int t = 0; t < N_THREADS; t++) begin
         wr_ptr_d[t] = wr_ptr_q[t];
         rd_ptr_d[t] = rd_ptr_q[t];
         cnt_d[t]    = cnt_q[t];
         if (wr_ok && (wr_thread_num == thr_t'(t)))
            wr_ptr_d[t] = wr_ptr_q[t] + ptr_t'(1);
         if (commit && (pend_thr_q == thr_t'(t)))
            rd_ptr_d[t] = rd_ptr_q[t] + ptr_t'(1);
         cnt_d[t] = cnt_q[t]
                  + cnt_t'(wr_ok && (wr_thread_num == thr_t'(t)))
                  - cnt_t'(commit && (pend_thr_q == thr_t'(t)));
         if (clr && (rd_thread_num == thr_t'(t))) begin
            wr_ptr_d[t] = '0;
            rd_ptr_d[t] = '0;
            cnt_d[t]    = '0;
         end
         full_d[t] = cnt_d[t] == cnt_t'(DEPTH);
      end
      pend_d     = lk_ok & ~clr;
      pend_thr_d = lk_ok ? rd_thread_num : pend_thr_q;
      dout_d     = lk_ok ? mem_q[rd_addr] : dout_q;
   end

   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem_q[wr_addr] <= din;
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < N_THREADS; t++) begin
            wr_ptr_q[t] <= '0;
            rd_ptr_q[t] <= '0;
            cnt_q[t]    <= '0;
         end
         full_q     <= '0;
         pend_q     <= 1'b0;
         pend_thr_q <= '0;
         dout_q     <= '0;
      end else begin
         for (int t = 0; t < N_THREADS; t++) begin
            wr_ptr_q[t] <= wr_ptr_d[t];
            rd_ptr_q[t] <= rd_ptr_d[t];
            cnt_q[t]    <= cnt_d[t];
         end
         full_q     <= full_d;
         pend_q     <= pend_d;
         pend_thr_q <= pend_thr_d;
         dout_q     <= dout_d;
      end
   end

   assign full = full_q;
   assign dout = dout_q;

`ifdef PROCB_BUF_ERR_EN
   logic [2:0] err_q, err_d;

   always_comb begin
      err_d = err_q | {rd_en & ~pend_q & ~rd_rst,
                       lookup_en & lookup_empty,
                       wr_en & full_q[wr_thread_num] & ~commit_wr};
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) err_q <= '0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = '0;
`endif

endmodule

// File: tb/tb_procb_buf.sv
// Directed table-driven bench for procb_buf.
// Expected error flags depend on PROCB_BUF_ERR_EN.
module tb_procb_buf;

   localparam int NT = 16;
`ifdef PROCB_BUF_ERR_EN
   localparam logic [2:0] EM = 3'b111;
`else
   localparam logic [2:0] EM = 3'b000;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_thread_num = '0;
   logic [31:0] din = '0;
   logic [15:0] full;
   logic [3:0]  rd_thread_num = '0;
   logic        lookup_en = 1'b0;
   logic        rd_en = 1'b0;
   logic        rd_rst = 1'b0;
   logic        lookup_empty;
   logic [31:0] dout;
   logic [2:0]  err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   procb_buf dut (
      .CLK(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_thread_num(wr_thread_num), .din(din),
      .full(full), .rd_thread_num(rd_thread_num),
      .lookup_en(lookup_en), .rd_en(rd_en), .rd_rst(rd_rst),
      .lookup_empty(lookup_empty), .dout(dout), .err(err)
   );

   typedef struct {
      logic        wr;
      logic [3:0]  wt;
      logic [31:0] d;
      logic [3:0]  rt;
      logic        lk;
      logic        re;
      logic        le;
      logic [31:0] dout;
      logic [15:0] full;
      logic [2:0]  err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic wr, logic [3:0] wt, logic [31:0] d,
                               logic [3:0] rt, logic lk, logic re, logic le,
                               logic [31:0] dx, logic [15:0] fx, logic [2:0] ex);
      vec_t v;
      v.wr = wr; v.wt = wt; v.d = d; v.rt = rt; v.lk = lk; v.re = re;
      v.le = le; v.dout = dx; v.full = fx; v.err = ex;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; lookup_en = 1'b0; rd_en = 1'b0; rd_rst = 1'b0;
   endtask

   localparam logic [31:0] A  = 32'hA000_0001, B  = 32'hB000_0002;
   localparam logic [31:0] A5 = 32'h5500_0005, C2 = 32'hC200_0002;
   localparam logic [31:0] D2 = 32'hD200_0002, E7 = 32'hE700_0007;
   localparam logic [31:0] F  = 32'hF000_0000, G  = 32'h9000_0000;

   initial begin
      vecs.push_back(mk(0,0,0, 3,0,0, 1, 0,0,0));
      vecs.push_back(mk(1,3,A, 3,0,0, 1, 0,0,0));
      vecs.push_back(mk(1,3,B, 3,0,0, 0, 0,0,0));
      vecs.push_back(mk(0,0,0, 3,1,0, 0, A,0,0));
      vecs.push_back(mk(0,0,0, 3,1,1, 0, B,0,0));
      vecs.push_back(mk(0,0,0, 3,0,1, 1, B,0,0));
      vecs.push_back(mk(0,0,0, 3,0,0, 1, B,0,0));
      vecs.push_back(mk(1,5,A5,5,0,0, 1, B,0,0));
      vecs.push_back(mk(0,0,0, 5,1,0, 0, A5,0,0));
      vecs.push_back(mk(0,0,0, 5,0,0, 1, A5,0,0));
      vecs.push_back(mk(0,0,0, 5,1,0, 0, A5,0,0));
      vecs.push_back(mk(0,0,0, 5,0,1, 1, A5,0,0));
      vecs.push_back(mk(0,0,0, 5,0,0, 1, A5,0,0));
      vecs.push_back(mk(1,2,C2,2,0,0, 1, A5,0,0));
      vecs.push_back(mk(1,2,D2,2,0,0, 0, A5,0,0));
      vecs.push_back(mk(1,7,E7,2,0,0, 0, A5,0,0));
      vecs.push_back(mk(0,0,0, 2,1,0, 0, C2,0,0));
      vecs.push_back(mk(0,0,0, 7,0,1, 0, C2,0,0));
      vecs.push_back(mk(0,0,0, 2,1,0, 0, D2,0,0));
      vecs.push_back(mk(0,0,0, 7,1,0, 0, E7,0,0));
      vecs.push_back(mk(0,0,0, 2,0,0, 0, E7,0,0));
      vecs.push_back(mk(1,0,F+0,0,0,0, 1, E7,16'h0000,0));
      vecs.push_back(mk(1,0,F+1,0,0,0, 0, E7,16'h0000,0));
      vecs.push_back(mk(1,0,F+2,0,0,0, 0, E7,16'h0000,0));
      vecs.push_back(mk(1,0,F+3,0,0,0, 0, E7,16'h0001,0));
      vecs.push_back(mk(1,0,F+4,0,0,0, 0, E7,16'h0001,3'b001));
      vecs.push_back(mk(0,0,0, 0,1,0, 0, F+0,16'h0001,3'b001));
      vecs.push_back(mk(0,0,0, 0,1,1, 0, F+1,16'h0000,3'b001));
      vecs.push_back(mk(0,0,0, 0,0,1, 0, F+1,16'h0000,3'b001));
      vecs.push_back(mk(1,9,G+0,9,0,0, 1, F+1,16'h0000,3'b001));
      vecs.push_back(mk(1,9,G+1,9,0,0, 0, F+1,16'h0000,3'b001));
      vecs.push_back(mk(1,9,G+2,9,0,0, 0, F+1,16'h0000,3'b001));
      vecs.push_back(mk(1,9,G+3,9,0,0, 0, F+1,16'h0200,3'b001));
      vecs.push_back(mk(0,0,0, 9,1,0, 0, G+0,16'h0200,3'b001));
      vecs.push_back(mk(1,9,G+4,9,0,1, 0, G+0,16'h0200,3'b001));
      vecs.push_back(mk(0,0,0, 9,1,0, 0, G+1,16'h0200,3'b001));
      vecs.push_back(mk(0,0,0, 9,1,1, 0, G+2,16'h0000,3'b001));
      vecs.push_back(mk(0,0,0, 9,1,1, 0, G+3,16'h0000,3'b001));
      vecs.push_back(mk(0,0,0, 9,1,1, 0, G+4,16'h0000,3'b001));
      vecs.push_back(mk(0,0,0, 9,0,1, 1, G+4,16'h0000,3'b001));
      vecs.push_back(mk(0,0,0, 9,1,0, 1, G+4,16'h0000,3'b011));
      vecs.push_back(mk(0,0,0, 9,0,1, 1, G+4,16'h0000,3'b111));

      #12 rst_n = 1'b1;
      chk("reset le", 32'(lookup_empty), 32'd1);
      chk("reset dout", dout, 32'd0);
      chk("reset full", 32'(full), 32'd0);
      chk("reset err", 32'(err), 32'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         wr_en = vecs[i].wr; wr_thread_num = vecs[i].wt; din = vecs[i].d;
         rd_thread_num = vecs[i].rt; lookup_en = vecs[i].lk;
         rd_en = vecs[i].re; rd_rst = 1'b0;
         #1 chk($sformatf("v%0d le", i), 32'(lookup_empty), 32'(vecs[i].le));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d dout", i), dout, vecs[i].dout);
         chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].full));
         chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err & EM));
      end

      for (int t = 0; t < NT; t++) begin
         @(negedge clk);
         idle();
         wr_en = 1'b1; wr_thread_num = 4'(t); din = 32'hC000_0000 | t;
      end
      @(negedge clk);
      idle();
      for (int t = 0; t < NT; t++) begin
         rd_thread_num = 4'(t);
         #1 chk($sformatf("fill le t%0d", t), 32'(lookup_empty), 32'd0);
      end

      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         idle();
         rd_thread_num = 4'(t); rd_en = 1'b1; rd_rst = 1'b1;
         if (t == 4) begin
            wr_en = 1'b1; wr_thread_num = 4'd4; din = 32'h4444_4444;
         end
      end
      @(negedge clk);
      idle();
      for (int t = 0; t < NT; t++) begin
         rd_thread_num = 4'(t);
         #1 chk($sformatf("sweep le t%0d", t), 32'(lookup_empty),
                32'(t < 8));
      end
      chk("sweep full", 32'(full), 32'd0);
      chk("sweep err", 32'(err), 32'(EM));

      @(negedge clk);
      rd_thread_num = 4'd8; rd_en = 1'b1; rd_rst = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      idle();
      chk("mid rst dout", dout, 32'd0);
      chk("mid rst full", 32'(full), 32'd0);
      chk("mid rst err", 32'(err), 32'd0);
      for (int t = 0; t < NT; t++) begin
         rd_thread_num = 4'(t);
         #0.1 chk($sformatf("rst le t%0d", t), 32'(lookup_empty), 32'd1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wr_en = 1'b1; wr_thread_num = 4'd3; din = 32'h3333_0003;
      rd_thread_num = 4'd3;
      @(negedge clk);
      idle();
      lookup_en = 1'b1;
      #1 chk("post le", 32'(lookup_empty), 32'd0);
      @(posedge clk);
      #1;
      chk("post dout", dout, 32'h3333_0003);
      chk("post err", 32'(err), 32'd0);
      @(negedge clk);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/procb_buf.md
# procb_buf

Per-thread queue of process_bytes (procb) records feeding the process_bytes stage of the sha512crypt unit. The CPU-side loader writes records {addr, bytes_cnt, finish_ctx, stop_ctx} per thread. process_bytes reads them through a speculative lookup that it commits one cycle later only if the data was accepted. An uncommitted lookup is discarded without side effects, so the same record is presented again next time.

## Interface
- N_THREADS, 16: number of threads (power of 2, min 4)
- N_THREADS_MSB, `MSB(N_THREADS-1): thread index MSB
- DEPTH, 4: records per thread (power of 2, min 2)
- DEPTH_MSB, `MSB(DEPTH-1): slot index MSB

- CLK  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one record
- wr_thread_num  in  N_THREADS_MSB+1  target thread of write
- din  in  `PROCB_D_WIDTH  record {addr, bytes_cnt, finish_ctx, stop_ctx}
- full  out  N_THREADS  per-thread full flags, registered
- rd_thread_num  in  N_THREADS_MSB+1  thread for lookup/empty/reset
- lookup_en  in  1  speculative read of next record
- rd_en  in  1  commit the lookup issued on the previous cycle
- rd_rst  in  1  with rd_en: clear queue of rd_thread_num
- lookup_empty  out  1  no uncommitted-and-unlooked record for rd_thread_num (combinational)
- dout  out  `PROCB_D_WIDTH  record from last lookup, registered
- err  out  3  sticky {rd_en_no_pending, lookup_when_empty, wr_when_full}

## Operation
- Storage: N_THREADS*DEPTH x `PROCB_D_WIDTH distributed RAM, addressed {thread, slot}.
- Per-thread state: wr_ptr, rd_ptr (DEPTH_MSB+1 bits each, wrap modulo DEPTH), cnt (DEPTH_MSB+2 bits, 0..DEPTH).
- Pending register: pend (1 bit), pend_thread. It records a lookup not yet committed.
- Write: wr_en & ~full[wr_thread_num] stores din at wr_ptr, increments wr_ptr and cnt. A write to a full thread is dropped.
- Lookahead offset: la = pend & (pend_thread == rd_thread_num).
- lookup_empty = (cnt[rd_thread_num] - la) == 0.
- Lookup: lookup_en & ~lookup_empty loads dout <= mem[rd_thread_num][rd_ptr+la], then sets pend=1 and pend_thread=rd_thread_num. lookup_en while empty leaves dout unchanged and clears pend.
- Without lookup_en, pend clears at the clock edge. An uncommitted lookup therefore expires after one cycle.
- Commit: rd_en & pend & ~rd_rst increments rd_ptr[pend_thread] and decrements cnt[pend_thread]. The commit applies to pend_thread even if rd_thread_num has changed.
- Back-to-back lookups on one thread (t, t+1) with commit at t+1 present consecutive records.
- Simultaneous write and commit on the same thread: cnt unchanged, both pointers advance.
- rd_rst & rd_en clears wr_ptr, rd_ptr and cnt of rd_thread_num, and clears pend. It has priority over a write to the same thread in the same cycle. Used to sweep all threads during init.
- full[t] <= (next cnt[t] == DEPTH).

## Timing
- Reset (rst_n low, async): all pointers/cnt 0, pend 0, full 0, dout 0, err 0; lookup_empty reads 1.
- Lookup latency: dout valid 1 cycle after lookup_en.
- Commit window: exactly the cycle after lookup_en. rd_en at any other time is ignored (flagged).
- Write-to-visible: a record written at edge t affects lookup_empty from cycle t+1.
- full updates 1 cycle after the write or commit that changes it.
- Reset asserted mid-operation discards all records and the pending lookup immediately.

## Configuration
- PROCB_BUF_ERR_EN defined: err bits set and hold until rst_n.
  - bit0: write to a full thread.
  - bit1: lookup_en while lookup_empty.
  - bit2: rd_en without pend (excluding rd_rst).
- PROCB_BUF_ERR_EN undefined: err tied to 0; the dropping/ignoring behaviour is unchanged.

## Test plan
- Write A,B to thread 3; lookup at t, rd_en at t+1; lookup at t+1, rd_en at t+2 -> dout=A at t+1, B at t+2; thread 3 cnt 0; lookup_empty=1 at t+2.
- Write A to thread 5; lookup at t, no rd_en at t+1; lookup at t+2 -> dout=A again; cnt stays 1 until the commit at t+3.
- Lookup thread 2 at t; at t+1 rd_thread_num=7 with rd_en -> thread 2 rd_ptr advances, thread 7 untouched.
- Write DEPTH=4 records to thread 0, then a 5th -> full[0]=1; 5th dropped; err[0]=1 with PROCB_BUF_ERR_EN, 0 without.
- Thread 9 full; same cycle: write to 9 plus commit of a pending lookup on 9 -> cnt stays 4, new record lands in the freed slot, order preserved.
- Records in threads 0..15; sweep rd_rst&rd_en over all threads, then pull rst_n low mid-sweep -> every thread empty; full=0, dout=0, err=0.
